// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// operation encodings, default geometry and the group-count helper.
package cla_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_ADC = 2'b01,
      OP_SUB = 2'b10,
      OP_SBB = 2'b11
   } op_e;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_GROUP = 4;
   localparam int unsigned NGROUPS   = DEF_WIDTH / DEF_GROUP;

   function automatic int unsigned ngroups(input int unsigned width, input int unsigned group);
      return width / group;
   endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit lookahead unit: in-group carries plus group
// propagate/generate for the second-level lookahead.
module cla_group #(
   parameter int unsigned GROUP = 4
) (
   input  logic [GROUP-1:0] p,
   input  logic [GROUP-1:0] g,
   input  logic             ci,
   output logic [GROUP-1:0] c,
   output logic             gp,
   output logic             gg
);

   logic term;

   // c[i] is the carry into bit i, expanded as a flat OR of products.
   always_comb begin
      c    = '0;
      gg   = 1'b0;
      term = 1'b0;
      for (int unsigned i = 0; i < GROUP; i++) begin
         term = ci;
         for (int unsigned j = 0; j < i; j++) term = term & p[j];
         c[i] = term;
         for (int unsigned k = 0; k < i; k++) begin
            term = g[k];
            for (int unsigned j = k + 1; j < i; j++) term = term & p[j];
            c[i] = c[i] | term;
         end
      end
      for (int unsigned k = 0; k < GROUP; k++) begin
         term = g[k];
         for (int unsigned j = k + 1; j < GROUP; j++) term = term & p[j];
         gg = gg | term;
      end
   end

   assign gp = &p;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead ADD/ADC/SUB/SBB with valid/ready
// handshakes on both sides and carry/overflow/zero/negative flags.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned GROUP = DEF_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned NG = ngroups(WIDTH, GROUP);

   if (WIDTH % GROUP != 0) begin : g_bad_width
      $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
   end
   if (!(GROUP == 2 || GROUP == 4 || GROUP == 8)) begin : g_bad_group
      $error("cla_pipe_addsub: GROUP must be 2, 4 or 8");
   end
   if (WIDTH < 8) begin : g_bad_min
      $error("cla_pipe_addsub: WIDTH must be at least 8");
   end

   logic             s1_valid, s2_valid, s1_adv, accept;
   logic [WIDTH-1:0] b_eff, p_d, g_d, gc_d;
   logic [NG-1:0]    gp_d, gg_d;
   logic             c0_d;

   logic [WIDTH-1:0] s1_p, s1_gc;
   logic [NG-1:0]    s1_gp, s1_gg;
   logic             s1_c0;

   logic [NG:0]      cg;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic             term;

   assign s1_adv    = !s2_valid || (s2_valid && out_ready);
   assign in_ready  = !s1_valid || s1_adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;

   always_comb begin
      b_eff = op[1] ? ~b : b;
      p_d   = a ^ b_eff;
      g_d   = a & b_eff;
      case (op_e'(op))
         OP_ADD:  c0_d = 1'b0;
         OP_SUB:  c0_d = 1'b1;
         default: c0_d = cin;
      endcase
   end

   // Groups are evaluated with a zero carry-in here; stage 2 folds the real
   // group carry back in as (prefix-propagate & group carry).
   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
         .p  (p_d[gi*GROUP +: GROUP]),
         .g  (g_d[gi*GROUP +: GROUP]),
         .ci (1'b0),
         .c  (gc_d[gi*GROUP +: GROUP]),
         .gp (gp_d[gi]),
         .gg (gg_d[gi])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_valid <= 1'b0;
      else        s1_valid <= accept || (s1_valid && !s1_adv);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_p  <= p_d;
         s1_gc <= gc_d;
         s1_gp <= gp_d;
         s1_gg <= gg_d;
         s1_c0 <= c0_d;
      end
   end

   always_comb begin
      cg    = '0;
      carry = '0;
      term  = 1'b0;
      cg[0] = s1_c0;
      for (int unsigned k = 1; k <= NG; k++) begin
         term = s1_c0;
         for (int unsigned j = 0; j < k; j++) term = term & s1_gp[j];
         cg[k] = term;
         for (int unsigned j = 0; j < k; j++) begin
            term = s1_gg[j];
            for (int unsigned m = j + 1; m < k; m++) term = term & s1_gp[m];
            cg[k] = cg[k] | term;
         end
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
         term = cg[i / GROUP];
         for (int unsigned j = (i / GROUP) * GROUP; j < i; j++) term = term & s1_p[j];
         carry[i] = s1_gc[i] | term;
      end
      carry[WIDTH] = cg[NG];
      sum_d        = s1_p ^ carry[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
         zero     <= 1'b0;
         neg      <= 1'b0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            sum  <= sum_d;
            cout <= carry[WIDTH];
            ovf  <= carry[WIDTH-1] ^ carry[WIDTH];
            zero <= ~|sum_d;
            neg  <= sum_d[WIDTH-1];
         end
      end
   end

endmodule
